// File: rtl/gpio_cmd_sequencer.sv
// GPIO command decoder driving the convolution control FSM.
// Toggle-paced commands in, status/read-back word with ack out.
module gpio_cmd_sequencer #(
   parameter int NB_GPIO  = 32,
   parameter int NB_IMAGE = 10,
   parameter int NB_DATA  = 8,
   parameter int NB_COEF  = 8,
   parameter int RD_LAT   = 2
) (
   input  logic                 i_CLK,
   input  logic                 i_reset,
   input  logic [NB_GPIO-1:0]   i_gpio_cmd,
   input  logic                 i_EoP,
   input  logic [NB_DATA-1:0]   i_rdData,
   output logic [NB_GPIO-1:0]   o_gpio_status,
   output logic                 o_fsm_reset,
   output logic                 o_load,
   output logic                 o_SoP,
   output logic                 o_valid,
   output logic [NB_IMAGE-1:0]  o_imgLength,
   output logic [NB_DATA-1:0]   o_wrData,
   output logic [9*NB_COEF-1:0] o_kernel
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      LOAD = 2'b01,
      PROC = 2'b10,
      READ = 2'b11
   } state_t;

   localparam logic [2:0] OP_NOP     = 3'b000;
   localparam logic [2:0] OP_RST     = 3'b001;
   localparam logic [2:0] OP_SET_LEN = 3'b010;
   localparam logic [2:0] OP_KERNEL  = 3'b011;
   localparam logic [2:0] OP_PHASE   = 3'b100;
   localparam logic [2:0] OP_PIXEL   = 3'b101;
   localparam logic [2:0] OP_PROCESS = 3'b110;
   localparam logic [2:0] OP_READ    = 3'b111;

   localparam int ROW_W = 3 * NB_COEF;
   localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   state_t stateQ, stateNxt;

   logic             togQ, togD;
   logic             busyQ, busyD;
   logic [CNT_W-1:0] cntQ, cntD;
   logic             errQ, errD;
   logic             ackQ, ackD;
   logic             eopQ;
   logic [NB_DATA-1:0] rdDataQ, rdDataD;

   logic                 loadD, sopD, validD, fsmResetD;
   logic [NB_IMAGE-1:0]  lenD;
   logic [NB_DATA-1:0]   wrDataD;
   logic [9*NB_COEF-1:0] kernelD;

   logic [2:0] opcode;
   logic       cmdTog;
   logic [1:0] row;
   logic       cmdNew;
   logic       legal;
   logic       exec;
   logic       unusedBits;

   assign opcode     = i_gpio_cmd[NB_GPIO-1 -: 3];
   assign cmdTog     = i_gpio_cmd[NB_GPIO-4];
   assign row        = i_gpio_cmd[25:24];
   assign unusedBits = ^i_gpio_cmd[27:26];

   // RST may break into a pending read; everything else waits for busy to drop
   assign cmdNew = (cmdTog != togQ) && (!busyQ || opcode == OP_RST);
   assign exec   = cmdNew && legal;

   always_comb begin
      legal = 1'b0;
      case (opcode)
         OP_NOP:     legal = 1'b1;
         OP_RST:     legal = 1'b1;
         OP_SET_LEN: legal = (stateQ == IDLE);
         OP_KERNEL:  legal = (stateQ == IDLE) && (row != 2'd3);
         OP_PHASE:   legal = i_gpio_cmd[0] ? (stateQ == IDLE)
                                           : (stateQ == LOAD || stateQ == READ);
         OP_PIXEL:   legal = (stateQ == LOAD);
         OP_PROCESS: legal = (stateQ == IDLE);
         OP_READ:    legal = (stateQ == READ);
         default:    legal = 1'b0;
      endcase
   end

   always_ff @(posedge i_CLK or posedge i_reset) begin
      if (i_reset) stateQ <= IDLE;
      else         stateQ <= stateNxt;
   end

   always_comb begin
      stateNxt = stateQ;
      if (stateQ == PROC && i_EoP) stateNxt = READ;
      if (exec) begin
         case (opcode)
            OP_RST:     stateNxt = IDLE;
            OP_PHASE:   stateNxt = i_gpio_cmd[0] ? LOAD : IDLE;
            OP_PROCESS: stateNxt = PROC;
            default:    ;
         endcase
      end
   end

   always_comb begin
      togD      = togQ;
      busyD     = busyQ;
      cntD      = cntQ;
      errD      = errQ;
      ackD      = ackQ;
      rdDataD   = rdDataQ;
      loadD     = o_load;
      sopD      = o_SoP;
      validD    = 1'b0;
      fsmResetD = 1'b0;
      lenD      = o_imgLength;
      wrDataD   = o_wrData;
      kernelD   = o_kernel;

      // read completes RD_LAT edges after the o_valid pulse edge
      if (busyQ) begin
         if (cntQ == CNT_W'(RD_LAT - 1)) begin
            busyD   = 1'b0;
            rdDataD = i_rdData;
            ackD    = togQ;
         end else begin
            cntD = cntQ + 1'b1;
         end
      end

      if (stateQ == PROC && i_EoP) sopD = 1'b0;

      if (cmdNew) begin
         togD = cmdTog;
         if (!(exec && opcode == OP_READ)) ackD = cmdTog;
         if (!legal) errD = 1'b1;
      end

      if (exec) begin
         case (opcode)
            OP_RST: begin
               fsmResetD = 1'b1;
               loadD     = 1'b0;
               sopD      = 1'b0;
               validD    = 1'b0;
               errD      = 1'b0;
               busyD     = 1'b0;
               rdDataD   = rdDataQ;
            end
            OP_SET_LEN: lenD = i_gpio_cmd[NB_IMAGE-1:0];
            OP_KERNEL: begin
               for (int r = 0; r < 3; r++) begin
                  if (row == 2'(r))
                     kernelD[r*ROW_W +: ROW_W] = i_gpio_cmd[ROW_W-1:0];
               end
            end
            OP_PHASE: loadD = i_gpio_cmd[0];
            OP_PIXEL: begin
               wrDataD = i_gpio_cmd[NB_DATA-1:0];
               validD  = 1'b1;
            end
            OP_PROCESS: sopD = 1'b1;
            OP_READ: begin
               validD = 1'b1;
               busyD  = 1'b1;
               cntD   = '0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_CLK or posedge i_reset) begin
      if (i_reset) begin
         togQ        <= 1'b0;
         busyQ       <= 1'b0;
         cntQ        <= '0;
         errQ        <= 1'b0;
         ackQ        <= 1'b0;
         eopQ        <= 1'b0;
         rdDataQ     <= '0;
         o_load      <= 1'b0;
         o_SoP       <= 1'b0;
         o_valid     <= 1'b0;
         o_fsm_reset <= 1'b0;
         o_imgLength <= '0;
         o_wrData    <= '0;
         o_kernel    <= '0;
      end else begin
         togQ        <= togD;
         busyQ       <= busyD;
         cntQ        <= cntD;
         errQ        <= errD;
         ackQ        <= ackD;
         eopQ        <= i_EoP;
         rdDataQ     <= rdDataD;
         o_load      <= loadD;
         o_SoP       <= sopD;
         o_valid     <= validD;
         o_fsm_reset <= fsmResetD;
         o_imgLength <= lenD;
         o_wrData    <= wrDataD;
         o_kernel    <= kernelD;
      end
   end

   assign o_gpio_status = {ackQ, stateQ, errQ, eopQ,
                           {(NB_GPIO-5-NB_DATA){1'b0}}, rdDataQ};

endmodule

// File: tb/tb_gpio_cmd_sequencer.sv
// Directed bench for gpio_cmd_sequencer.
// Commands driven on negedge, outputs sampled on negedge.
module tb_gpio_cmd_sequencer;

   logic        i_CLK;
   logic        i_reset;
   logic [31:0] i_gpio_cmd;
   logic        i_EoP;
   logic [7:0]  i_rdData;
   logic [31:0] o_gpio_status;
   logic        o_fsm_reset;
   logic        o_load;
   logic        o_SoP;
   logic        o_valid;
   logic [9:0]  o_imgLength;
   logic [7:0]  o_wrData;
   logic [71:0] o_kernel;

   int checks = 0;
   int errors = 0;
   logic tbTog = 1'b0;

   gpio_cmd_sequencer dut (
      .i_CLK(i_CLK),
      .i_reset(i_reset),
      .i_gpio_cmd(i_gpio_cmd),
      .i_EoP(i_EoP),
      .i_rdData(i_rdData),
      .o_gpio_status(o_gpio_status),
      .o_fsm_reset(o_fsm_reset),
      .o_load(o_load),
      .o_SoP(o_SoP),
      .o_valid(o_valid),
      .o_imgLength(o_imgLength),
      .o_wrData(o_wrData),
      .o_kernel(o_kernel)
   );

   initial i_CLK = 1'b0;
   always #5 i_CLK = ~i_CLK;

   // entered just after a negedge; returns at the negedge after the executing edge
   task automatic send(input logic [2:0] op, input logic [27:0] pl);
      tbTog = ~tbTog;
      i_gpio_cmd = {op, tbTog, pl};
      @(negedge i_CLK);
   endtask

   task automatic test_reset;
      i_reset = 1'b1;
      i_gpio_cmd = '0;
      i_EoP = 1'b0;
      i_rdData = '0;
      repeat (3) @(negedge i_CLK);
      checks++;
      if (o_gpio_status !== 32'h0) begin
         errors++;
         $display("FAIL reset_status got %h exp %h", o_gpio_status, 32'h0);
      end
      checks++;
      if ({o_fsm_reset, o_load, o_SoP, o_valid} !== 4'b0) begin
         errors++;
         $display("FAIL reset_ctrl got %b exp 0000",
                  {o_fsm_reset, o_load, o_SoP, o_valid});
      end
      checks++;
      if (o_kernel !== 72'h0 || o_imgLength !== 10'h0) begin
         errors++;
         $display("FAIL reset_regs got %h/%h exp 0/0", o_kernel, o_imgLength);
      end
      i_reset = 1'b0;
      tbTog = 1'b0;
      @(negedge i_CLK);
   endtask

   task automatic test_len_rst;
      send(3'b010, 28'h1FF);
      checks++;
      if (o_imgLength !== 10'h1FF) begin
         errors++;
         $display("FAIL set_len got %h exp %h", o_imgLength, 10'h1FF);
      end
      send(3'b001, 28'h0);
      checks++;
      if (o_fsm_reset !== 1'b1) begin
         errors++;
         $display("FAIL rst_pulse_hi got %b exp 1", o_fsm_reset);
      end
      checks++;
      if (o_gpio_status[30:29] !== 2'b00 || o_gpio_status[31] !== tbTog) begin
         errors++;
         $display("FAIL rst_status got st=%b ack=%b exp st=00 ack=%b",
                  o_gpio_status[30:29], o_gpio_status[31], tbTog);
      end
      @(negedge i_CLK);
      checks++;
      if (o_fsm_reset !== 1'b0) begin
         errors++;
         $display("FAIL rst_pulse_lo got %b exp 0", o_fsm_reset);
      end
      checks++;
      if (o_imgLength !== 10'h1FF) begin
         errors++;
         $display("FAIL len_kept got %h exp %h", o_imgLength, 10'h1FF);
      end
   endtask

   task automatic test_load_pixels;
      logic [7:0] pix [3];
      pix[0] = 8'h11;
      pix[1] = 8'h22;
      pix[2] = 8'h33;
      send(3'b100, 28'h1);
      checks++;
      if (o_load !== 1'b1 || o_gpio_status[30:29] !== 2'b01) begin
         errors++;
         $display("FAIL phase1 got load=%b st=%b exp 1/01",
                  o_load, o_gpio_status[30:29]);
      end
      for (int i = 0; i < 3; i++) begin
         send(3'b101, {20'h0, pix[i]});
         checks++;
         if (o_valid !== 1'b1 || o_wrData !== pix[i] || o_load !== 1'b1) begin
            errors++;
            $display("FAIL pixel%0d got v=%b d=%h l=%b exp 1/%h/1",
                     i, o_valid, o_wrData, o_load, pix[i]);
         end
         @(negedge i_CLK);
         checks++;
         if (o_valid !== 1'b0 || o_wrData !== pix[i]) begin
            errors++;
            $display("FAIL pixel%0d_end got v=%b d=%h exp 0/%h",
                     i, o_valid, o_wrData, pix[i]);
         end
      end
      send(3'b100, 28'h0);
      checks++;
      if (o_load !== 1'b0 || o_gpio_status[30:29] !== 2'b00) begin
         errors++;
         $display("FAIL phase0 got load=%b st=%b exp 0/00",
                  o_load, o_gpio_status[30:29]);
      end
   endtask

   task automatic test_kernel;
      send(3'b011, {4'b0000, 24'h030201});
      send(3'b011, {4'b0001, 24'h060504});
      send(3'b011, {4'b0010, 24'h090807});
      checks++;
      if (o_kernel !== 72'h090807060504030201) begin
         errors++;
         $display("FAIL kernel got %h exp %h", o_kernel, 72'h090807060504030201);
      end
      checks++;
      if (o_gpio_status[28] !== 1'b0) begin
         errors++;
         $display("FAIL kernel_err_clear got %b exp 0", o_gpio_status[28]);
      end
      send(3'b011, {4'b0011, 24'hFFFFFF});
      checks++;
      if (o_gpio_status[28] !== 1'b1 || o_kernel !== 72'h090807060504030201) begin
         errors++;
         $display("FAIL kernel_r3 got err=%b k=%h exp 1/%h",
                  o_gpio_status[28], o_kernel, 72'h090807060504030201);
      end
      send(3'b001, 28'h0);
      checks++;
      if (o_gpio_status[28] !== 1'b0) begin
         errors++;
         $display("FAIL err_cleared got %b exp 0", o_gpio_status[28]);
      end
   endtask

   task automatic enter_read;
      send(3'b110, 28'h0);
      checks++;
      if (o_SoP !== 1'b1 || o_gpio_status[30:29] !== 2'b10) begin
         errors++;
         $display("FAIL process got sop=%b st=%b exp 1/10",
                  o_SoP, o_gpio_status[30:29]);
      end
      i_EoP = 1'b1;
      @(negedge i_CLK);
      i_EoP = 1'b0;
      checks++;
      if (o_SoP !== 1'b0 || o_gpio_status[30:27] !== 4'b1101) begin
         errors++;
         $display("FAIL eop got sop=%b st/err/eop=%b exp 0/1101",
                  o_SoP, o_gpio_status[30:27]);
      end
   endtask

   task automatic test_process;
      bit ok;
      send(3'b110, 28'h0);
      checks++;
      if (o_SoP !== 1'b1 || o_gpio_status[30:29] !== 2'b10) begin
         errors++;
         $display("FAIL process got sop=%b st=%b exp 1/10",
                  o_SoP, o_gpio_status[30:29]);
      end
      send(3'b101, 28'h44);
      checks++;
      if (o_gpio_status[28] !== 1'b1 || o_valid !== 1'b0 || o_wrData !== 8'h33) begin
         errors++;
         $display("FAIL pixel_in_proc got err=%b v=%b d=%h exp 1/0/33",
                  o_gpio_status[28], o_valid, o_wrData);
      end
      ok = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge i_CLK);
         if (o_SoP !== 1'b1 || o_gpio_status[30:29] !== 2'b10) ok = 1'b0;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL sop_hold got sop=%b st=%b exp 1/10",
                  o_SoP, o_gpio_status[30:29]);
      end
      i_EoP = 1'b1;
      @(negedge i_CLK);
      i_EoP = 1'b0;
      checks++;
      if (o_SoP !== 1'b0 || o_gpio_status[30:27] !== 4'b1111) begin
         errors++;
         $display("FAIL eop got sop=%b st/err/eop=%b exp 0/1111",
                  o_SoP, o_gpio_status[30:27]);
      end
      @(negedge i_CLK);
      checks++;
      if (o_gpio_status[27] !== 1'b0 || o_gpio_status[30:29] !== 2'b11) begin
         errors++;
         $display("FAIL eop_drop got eop=%b st=%b exp 0/11",
                  o_gpio_status[27], o_gpio_status[30:29]);
      end
   endtask

   task automatic test_read;
      logic prevTog;
      prevTog = tbTog;
      i_rdData = 8'h00;
      send(3'b111, 28'h0);
      checks++;
      if (o_valid !== 1'b1 || o_gpio_status[31] !== prevTog) begin
         errors++;
         $display("FAIL read_pulse got v=%b ack=%b exp 1/%b",
                  o_valid, o_gpio_status[31], prevTog);
      end
      send(3'b000, 28'h0);
      checks++;
      if (o_valid !== 1'b0 || o_gpio_status[31] !== prevTog) begin
         errors++;
         $display("FAIL read_busy got v=%b ack=%b exp 0/%b",
                  o_valid, o_gpio_status[31], prevTog);
      end
      i_rdData = 8'hA5;
      @(negedge i_CLK);
      i_rdData = 8'h5A;
      checks++;
      if (o_gpio_status[7:0] !== 8'hA5 || o_gpio_status[31] !== ~prevTog) begin
         errors++;
         $display("FAIL read_done got d=%h ack=%b exp a5/%b",
                  o_gpio_status[7:0], o_gpio_status[31], ~prevTog);
      end
      @(negedge i_CLK);
      checks++;
      if (o_gpio_status[31] !== prevTog || o_gpio_status[7:0] !== 8'hA5) begin
         errors++;
         $display("FAIL deferred_nop got ack=%b d=%h exp %b/a5",
                  o_gpio_status[31], o_gpio_status[7:0], prevTog);
      end
      send(3'b100, 28'h0);
      checks++;
      if (o_gpio_status[30:29] !== 2'b00) begin
         errors++;
         $display("FAIL read_exit got st=%b exp 00", o_gpio_status[30:29]);
      end
   endtask

   task automatic test_read_abort;
      send(3'b001, 28'h0);
      enter_read();
      i_rdData = 8'h3C;
      send(3'b111, 28'h0);
      checks++;
      if (o_valid !== 1'b1) begin
         errors++;
         $display("FAIL abort_pulse got v=%b exp 1", o_valid);
      end
      send(3'b001, 28'h0);
      checks++;
      if (o_fsm_reset !== 1'b1 || o_gpio_status[31:29] !== {tbTog, 2'b00}) begin
         errors++;
         $display("FAIL abort_rst got r=%b ack/st=%b exp 1/%b00",
                  o_fsm_reset, o_gpio_status[31:29], tbTog);
      end
      @(negedge i_CLK);
      @(negedge i_CLK);
      checks++;
      if (o_gpio_status[7:0] !== 8'hA5) begin
         errors++;
         $display("FAIL abort_data got %h exp a5", o_gpio_status[7:0]);
      end
   endtask

   task automatic test_async_reset;
      send(3'b100, 28'h1);
      if (tbTog == 1'b0) send(3'b000, 28'h0);
      send(3'b101, 28'h77);
      checks++;
      if (o_valid !== 1'b1 || o_load !== 1'b1 || tbTog !== 1'b0) begin
         errors++;
         $display("FAIL pre_areset got v=%b l=%b t=%b exp 1/1/0",
                  o_valid, o_load, tbTog);
      end
      #1 i_reset = 1'b1;
      #1;
      checks++;
      if ({o_fsm_reset, o_load, o_SoP, o_valid} !== 4'b0 || o_wrData !== 8'h0) begin
         errors++;
         $display("FAIL areset_ctrl got %b d=%h exp 0000/00",
                  {o_fsm_reset, o_load, o_SoP, o_valid}, o_wrData);
      end
      checks++;
      if (o_gpio_status !== 32'h0 || o_kernel !== 72'h0 || o_imgLength !== 10'h0) begin
         errors++;
         $display("FAIL areset_regs got %h/%h/%h exp 0/0/0",
                  o_gpio_status, o_kernel, o_imgLength);
      end
      @(negedge i_CLK);
      i_reset = 1'b0;
      repeat (3) @(negedge i_CLK);
      checks++;
      if (o_gpio_status !== 32'h0 || o_valid !== 1'b0) begin
         errors++;
         $display("FAIL stale_tog got st=%h v=%b exp 0/0", o_gpio_status, o_valid);
      end
      send(3'b000, 28'h0);
      checks++;
      if (o_gpio_status[31] !== 1'b1) begin
         errors++;
         $display("FAIL post_reset_ack got %b exp 1", o_gpio_status[31]);
      end
   endtask

   initial begin
      test_reset();
      test_len_rst();
      test_load_pixels();
      test_kernel();
      test_process();
      test_read();
      test_read_abort();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
